// File: rtl/int_ctrl_pkg.sv
// rtl/int_ctrl_pkg.sv - shared types and constants for the interrupt controller
package int_ctrl_pkg;

  localparam int IRQ_W = 8;
  localparam int NUM_W = 3;

  localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_0100;
  localparam int          DEF_VEC_STRIDE = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/int_prio8.sv
// rtl/int_prio8.sv - lowest-index-wins priority picker over eight request lines
module int_prio8
  import int_ctrl_pkg::*;
(
  input  logic [IRQ_W-1:0] req,
  output logic [NUM_W-1:0] idx,
  output logic             valid
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = IRQ_W - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = NUM_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - edge-detecting interrupt controller with enable mask and single-level service FSM
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter logic [31:0] VEC_BASE   = DEF_VEC_BASE,
  parameter int          VEC_STRIDE = DEF_VEC_STRIDE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             int_in,
  input  logic [NUM_W-1:0] intnum_in,
  input  logic             ie_we,
  input  logic [IRQ_W-1:0] ie_wdata,
  input  logic             gie,
  input  logic             ack,
  input  logic             iret,
  output logic             irq_req,
  output logic [NUM_W-1:0] irq_num,
  output logic [31:0]      irq_vec,
  output logic [IRQ_W-1:0] pending,
  output logic [IRQ_W-1:0] ie,
  output logic             in_service
);

  state_t             state;
  logic               prev_int;
  logic [NUM_W-1:0]   prev_num;
  logic               evt;
  logic [IRQ_W-1:0]   set_mask;
  logic [IRQ_W-1:0]   clr_mask;
  logic [NUM_W-1:0]   pick_idx;
  logic               pick_valid;

  // A held int_in only counts again when the encoded number changes.
  assign evt      = int_in && (!prev_int || (intnum_in != prev_num));
  assign set_mask = evt ? (IRQ_W'(1) << intnum_in) : '0;
  assign clr_mask = ((state == ST_REQ) && ack) ? (IRQ_W'(1) << irq_num) : '0;

  assign irq_vec = VEC_BASE + (32'(irq_num) * 32'(VEC_STRIDE));

  int_prio8 u_prio (
    .req   (pending & ie),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_int <= 1'b0;
      prev_num <= '0;
      pending  <= '0;
      ie       <= '0;
    end else begin
      prev_int <= int_in;
      prev_num <= intnum_in;
      pending  <= (pending & ~clr_mask) | set_mask;
      if (ie_we) begin
        ie <= ie_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      irq_req    <= 1'b0;
      irq_num    <= '0;
      in_service <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gie && pick_valid) begin
            state   <= ST_REQ;
            irq_req <= 1'b1;
            irq_num <= pick_idx;
          end
        end
        ST_REQ: begin
          if (ack) begin
            state      <= ST_SERVICE;
            irq_req    <= 1'b0;
            in_service <= 1'b1;
          end else if (!gie) begin
            state   <= ST_IDLE;
            irq_req <= 1'b0;
          end
        end
        ST_SERVICE: begin
          if (iret) begin
            state      <= ST_IDLE;
            in_service <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          irq_req    <= 1'b0;
          in_service <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - directed vector bench for int_ctrl
module tb_int_ctrl;

  logic        clk;
  logic        rst;
  logic        int_in;
  logic [2:0]  intnum_in;
  logic        ie_we;
  logic [7:0]  ie_wdata;
  logic        gie;
  logic        ack;
  logic        iret;
  logic        irq_req;
  logic [2:0]  irq_num;
  logic [31:0] irq_vec;
  logic [7:0]  pending;
  logic [7:0]  ie;
  logic        in_service;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       int_in;
    logic [2:0] num;
    logic       ie_we;
    logic [7:0] wdata;
    logic       gie;
    logic       ack;
    logic       iret;
    logic [7:0] e_pend;
    logic [7:0] e_ie;
    logic       e_req;
    logic [2:0] e_num;
    logic       e_svc;
  } vec_t;

  localparam int NV = 30;
  vec_t vecs [NV];

  int_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .int_in     (int_in),
    .intnum_in  (intnum_in),
    .ie_we      (ie_we),
    .ie_wdata   (ie_wdata),
    .gie        (gie),
    .ack        (ack),
    .iret       (iret),
    .irq_req    (irq_req),
    .irq_num    (irq_num),
    .irq_vec    (irq_vec),
    .pending    (pending),
    .ie         (ie),
    .in_service (in_service)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic i, logic [2:0] n, logic we, logic [7:0] wd,
                              logic g, logic a, logic r, logic [7:0] ep,
                              logic [7:0] ei, logic eq, logic [2:0] en, logic es);
    vec_t v;
    v.int_in = i; v.num = n; v.ie_we = we; v.wdata = wd; v.gie = g; v.ack = a; v.iret = r;
    v.e_pend = ep; v.e_ie = ei; v.e_req = eq; v.e_num = en; v.e_svc = es;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] ep, input logic [7:0] ei,
                           input logic eq, input logic [2:0] en, input logic es);
    check({tag, " pending"}, 32'(pending), 32'(ep));
    check({tag, " ie"}, 32'(ie), 32'(ei));
    check({tag, " irq_req"}, 32'(irq_req), 32'(eq));
    check({tag, " irq_num"}, 32'(irq_num), 32'(en));
    check({tag, " in_service"}, 32'(in_service), 32'(es));
    check({tag, " irq_vec"}, irq_vec, 32'h100 + 32'(en) * 32'd4);
  endtask

  task automatic drive(input logic i, input logic [2:0] n, input logic we, input logic [7:0] wd,
                       input logic g, input logic a, input logic r);
    int_in = i; intnum_in = n; ie_we = we; ie_wdata = wd; gie = g; ack = a; iret = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = mk(0,0,1,8'hFF,1,0,0, 8'h00,8'hFF,0,0,0);
    vecs[1]  = mk(1,5,0,8'h00,1,0,0, 8'h20,8'hFF,0,0,0);
    vecs[2]  = mk(0,0,0,8'h00,1,0,0, 8'h20,8'hFF,1,5,0);
    vecs[3]  = mk(0,0,0,8'h00,1,1,0, 8'h00,8'hFF,0,5,1);
    vecs[4]  = mk(0,0,0,8'h00,1,0,1, 8'h00,8'hFF,0,5,0);
    vecs[5]  = mk(1,3,0,8'h00,0,0,0, 8'h08,8'hFF,0,5,0);
    vecs[6]  = mk(1,6,0,8'h00,0,0,0, 8'h48,8'hFF,0,5,0);
    vecs[7]  = mk(0,0,0,8'h00,1,0,0, 8'h48,8'hFF,1,3,0);
    vecs[8]  = mk(0,0,0,8'h00,1,1,0, 8'h40,8'hFF,0,3,1);
    vecs[9]  = mk(0,0,0,8'h00,1,0,0, 8'h40,8'hFF,0,3,1);
    vecs[10] = mk(0,0,0,8'h00,1,0,1, 8'h40,8'hFF,0,3,0);
    vecs[11] = mk(0,0,0,8'h00,1,0,0, 8'h40,8'hFF,1,6,0);
    vecs[12] = mk(0,0,0,8'h00,1,1,0, 8'h00,8'hFF,0,6,1);
    vecs[13] = mk(0,0,0,8'h00,1,0,1, 8'h00,8'hFF,0,6,0);
    vecs[14] = mk(0,0,1,8'h00,0,0,0, 8'h00,8'h00,0,6,0);
    vecs[15] = mk(1,2,0,8'h00,1,0,0, 8'h04,8'h00,0,6,0);
    vecs[16] = mk(1,2,0,8'h00,1,1,1, 8'h04,8'h00,0,6,0);
    vecs[17] = mk(0,0,1,8'h04,1,0,0, 8'h04,8'h04,0,6,0);
    vecs[18] = mk(0,0,0,8'h00,1,0,0, 8'h04,8'h04,1,2,0);
    vecs[19] = mk(0,0,0,8'h00,0,0,0, 8'h04,8'h04,0,2,0);
    vecs[20] = mk(0,0,0,8'h00,1,0,0, 8'h04,8'h04,1,2,0);
    vecs[21] = mk(0,0,0,8'h00,0,1,0, 8'h00,8'h04,0,2,1);
    vecs[22] = mk(0,0,0,8'h00,0,0,1, 8'h00,8'h04,0,2,0);
    vecs[23] = mk(1,1,1,8'hFF,1,0,0, 8'h02,8'hFF,0,2,0);
    vecs[24] = mk(0,0,0,8'h00,1,0,0, 8'h02,8'hFF,1,1,0);
    vecs[25] = mk(1,1,0,8'h00,1,1,0, 8'h02,8'hFF,0,1,1);
    vecs[26] = mk(0,0,0,8'h00,1,0,0, 8'h02,8'hFF,0,1,1);
    vecs[27] = mk(0,0,0,8'h00,1,0,1, 8'h02,8'hFF,0,1,0);
    vecs[28] = mk(0,0,0,8'h00,1,0,0, 8'h02,8'hFF,1,1,0);
    vecs[29] = mk(0,0,0,8'h00,1,1,0, 8'h00,8'hFF,0,1,1);

    rst = 1'b1;
    drive(0, 0, 0, 8'h00, 0, 0, 0);
    #12;
    check_all("reset", 8'h00, 8'h00, 0, 0, 0);
    rst = 1'b0;

    for (int k = 0; k < NV; k++) begin
      drive(vecs[k].int_in, vecs[k].num, vecs[k].ie_we, vecs[k].wdata,
            vecs[k].gie, vecs[k].ack, vecs[k].iret);
      step();
      check_all($sformatf("vec%0d", k), vecs[k].e_pend, vecs[k].e_ie,
                vecs[k].e_req, vecs[k].e_num, vecs[k].e_svc);
    end

    // New event for the in-service irq while servicing, then async reset mid-service.
    drive(1, 1, 0, 8'h00, 1, 0, 0);
    step();
    check_all("svc_evt", 8'h02, 8'hFF, 0, 1, 1);
    drive(0, 0, 0, 8'h00, 1, 0, 0);
    step();
    check_all("svc_hold", 8'h02, 8'hFF, 0, 1, 1);
    #2 rst = 1'b1;
    #1;
    check_all("async_rst", 8'h00, 8'h00, 0, 0, 0);
    step();
    rst = 1'b0;
    drive(0, 0, 1, 8'hFF, 1, 0, 0);
    step();
    drive(0, 0, 0, 8'h00, 1, 0, 0);
    step();
    check_all("post_rst_idle", 8'h00, 8'hFF, 0, 0, 0);
    drive(1, 4, 0, 8'h00, 1, 0, 0);
    step();
    check_all("fresh_evt", 8'h10, 8'hFF, 0, 0, 0);
    drive(0, 0, 0, 8'h00, 1, 0, 0);
    step();
    check_all("fresh_req", 8'h10, 8'hFF, 1, 4, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
